// File: rtl/shift_unit_pipe_if.sv
// Request/response bundle for the pipelined shifter: issue side, result side,
// flush and busy. The unit itself connects through the slave modport.
interface shift_unit_pipe_if #(
   parameter int XLEN = 32,
   parameter int TAGW = 5
);
   localparam int SHW = $clog2(XLEN);

   logic            flush_i;
   logic            in_valid_i;
   logic            in_ready_o;
   logic [1:0]      op_i;
   logic [XLEN-1:0] a_i;
   logic [SHW-1:0]  shift_i;
   logic [TAGW-1:0] tag_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [XLEN-1:0] s_o;
   logic [TAGW-1:0] tag_o;
   logic            busy_o;

   modport slave (
      input  flush_i, in_valid_i, op_i, a_i, shift_i, tag_i, out_ready_i,
      output in_ready_o, out_valid_o, s_o, tag_o, busy_o
   );

   modport master (
      output flush_i, in_valid_i, op_i, a_i, shift_i, tag_i, out_ready_i,
      input  in_ready_o, out_valid_o, s_o, tag_o, busy_o
   );
endinterface

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL). The log2(XLEN) shift levels are
// spread over STAGES registered stages with a valid/ready chain and a tag sideband.
module shift_unit_pipe #(
   parameter int XLEN   = 32,
   parameter int STAGES = 2,
   parameter int TAGW   = 5
) (
   input logic             clk_i,
   input logic             rst_i,
   shift_unit_pipe_if.slave bus
);
   localparam int SHW = $clog2(XLEN);
   // Levels handled per stage, lowest levels first; trailing stages may get none.
   localparam int LPS = (SHW + STAGES - 1) / STAGES;

   logic [STAGES-1:0] r_valid;
   logic [XLEN-1:0]   r_data  [STAGES];
   logic [SHW-1:0]    r_shift [STAGES];
   logic [1:0]        r_op    [STAGES];
   logic              r_sign  [STAGES];
   logic [TAGW-1:0]   r_tag   [STAGES];

   logic [STAGES-1:0] w_src_valid;
   logic [STAGES-1:0] w_src_sign;
   logic [STAGES-1:0] w_adv;
   logic [XLEN-1:0]   w_src_data  [STAGES];
   logic [XLEN-1:0]   w_lvl_data  [STAGES];
   logic [SHW-1:0]    w_src_shift [STAGES];
   logic [1:0]        w_src_op    [STAGES];
   logic [TAGW-1:0]   w_src_tag   [STAGES];

   // Applies the levels k in [lo, hi) selected by the shift amount bits.
   function automatic logic [XLEN-1:0] shift_levels(
      input logic [XLEN-1:0] d,
      input logic [SHW-1:0]  sh,
      input logic [1:0]      op,
      input logic            sign,
      input int              lo,
      input int              hi
   );
      logic [XLEN-1:0] v;
      int              amt;
      v = d;
      for (int k = 0; k < SHW; k++) begin
         amt = 1 << k;
         if (k >= lo && k < hi && sh[k]) begin
            case (op)
               2'b00:   v = v << amt;
               2'b01:   v = v >> amt;
               2'b10:   v = (v >> amt) | ({XLEN{sign}} & ~({XLEN{1'b1}} >> amt));
               default: v = (v << amt) | (v >> (XLEN - amt));
            endcase
         end
      end
      return v;
   endfunction

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO = gi * LPS;
      localparam int HI = ((gi + 1) * LPS > SHW) ? SHW : (gi + 1) * LPS;

      if (gi == 0) begin : g_from_input
         assign w_src_valid[gi] = bus.in_valid_i;
         assign w_src_data[gi]  = bus.a_i;
         assign w_src_shift[gi] = bus.shift_i;
         assign w_src_op[gi]    = bus.op_i;
         assign w_src_sign[gi]  = bus.a_i[XLEN-1];
         assign w_src_tag[gi]   = bus.tag_i;
      end else begin : g_from_prev
         assign w_src_valid[gi] = r_valid[gi-1];
         assign w_src_data[gi]  = r_data[gi-1];
         assign w_src_shift[gi] = r_shift[gi-1];
         assign w_src_op[gi]    = r_op[gi-1];
         assign w_src_sign[gi]  = r_sign[gi-1];
         assign w_src_tag[gi]   = r_tag[gi-1];
      end

      assign w_lvl_data[gi] = shift_levels(w_src_data[gi], w_src_shift[gi], w_src_op[gi],
                                           w_src_sign[gi], LO, HI);
   end

   // A stage may load when it is empty or its occupant leaves this cycle.
   always_comb begin
      w_adv = '0;
      w_adv[STAGES-1] = !r_valid[STAGES-1] || bus.out_ready_i;
      for (int s = STAGES - 2; s >= 0; s--) begin
         w_adv[s] = !r_valid[s] || w_adv[s+1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid <= '0;
         for (int s = 0; s < STAGES; s++) begin
            r_data[s]  <= '0;
            r_shift[s] <= '0;
            r_op[s]    <= '0;
            r_sign[s]  <= 1'b0;
            r_tag[s]   <= '0;
         end
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (bus.flush_i) begin
               r_valid[s] <= 1'b0;
            end else if (w_adv[s]) begin
               r_valid[s] <= w_src_valid[s];
            end
            if (w_adv[s] && w_src_valid[s]) begin
               r_data[s]  <= w_lvl_data[s];
               r_shift[s] <= w_src_shift[s];
               r_op[s]    <= w_src_op[s];
               r_sign[s]  <= w_src_sign[s];
               r_tag[s]   <= w_src_tag[s];
            end
         end
      end
   end

   assign bus.in_ready_o  = w_adv[0];
   assign bus.out_valid_o = r_valid[STAGES-1];
   assign bus.s_o         = r_data[STAGES-1];
   assign bus.tag_o       = r_tag[STAGES-1];
   assign bus.busy_o      = |r_valid;
endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed and swept checks of shift_unit_pipe against an arithmetic shift model
// with an in-order scoreboard of accepted operations.
module tb_shift_unit_pipe;
   localparam int XLEN   = 32;
   localparam int STAGES = 2;
   localparam int TAGW   = 5;
   localparam int SHW    = $clog2(XLEN);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROL = 2'b11;

   typedef struct {
      logic [XLEN-1:0] s;
      logic [TAGW-1:0] tag;
      int              cyc;
   } item_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   int    n_vec = 0;
   int    n_err = 0;
   int    cyc_n = 0;
   bit    exact_lat = 1'b0;
   item_t sb[$];
   item_t got[$];

   shift_unit_pipe_if #(.XLEN(XLEN), .TAGW(TAGW)) bus ();

   shift_unit_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAGW(TAGW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [XLEN-1:0] ref_shift(input logic [1:0] op,
                                                 input logic [XLEN-1:0] a, input int sh);
      logic [XLEN-1:0] r;
      case (op)
         OP_SLL:  r = a << sh;
         OP_SRL:  r = a >> sh;
         OP_SRA:  r = $signed(a) >>> sh;
         default: r = (sh == 0) ? a : ((a << sh) | (a >> (XLEN - sh)));
      endcase
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] got_v, input logic [63:0] exp_v);
      n_vec++;
      if (got_v !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got_v, exp_v, cyc_n);
      end
   endtask

   // Scoreboard: checks outputs whenever meaningful, pops on transfer, pushes on accept.
   always @(negedge clk) begin : mon
      item_t it;
      int    lat;
      cyc_n++;
      if (rst) begin
         sb.delete();
      end else begin
         chk("busy", bus.busy_o, sb.size() != 0);
         chk("in_ready", bus.in_ready_o, !(sb.size() == STAGES && !bus.out_ready_i));
         if (bus.out_valid_o) begin
            if (sb.size() == 0) begin
               chk("spurious_out_valid", bus.out_valid_o, 1'b0);
            end else begin
               chk("s_o", bus.s_o, sb[0].s);
               chk("tag_o", bus.tag_o, sb[0].tag);
               if (bus.out_ready_i) begin
                  lat = cyc_n - sb[0].cyc;
                  if (exact_lat) chk("latency", lat, STAGES);
                  else chk("latency_min", lat >= STAGES, 1'b1);
                  $display("txn tag=%0d s=0x%h lat=%0d", bus.tag_o, bus.s_o, lat);
                  got.push_back(sb.pop_front());
               end
            end
         end
         if (bus.flush_i) begin
            sb.delete();
         end else if (bus.in_valid_i && bus.in_ready_o) begin
            it.s   = ref_shift(bus.op_i, bus.a_i, int'(bus.shift_i));
            it.tag = bus.tag_i;
            it.cyc = cyc_n;
            sb.push_back(it);
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input int sh,
                        input logic [TAGW-1:0] tag);
      int n = 0;
      bus.in_valid_i = 1'b1;
      bus.op_i       = op;
      bus.a_i        = a;
      bus.shift_i    = SHW'(sh);
      bus.tag_i      = tag;
      @(negedge clk);
      while (!bus.in_ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("issue_accept", bus.in_ready_o, 1'b1);
      @(posedge clk); #1;
      bus.in_valid_i = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain", sb.size(), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  idx;
      int  guard;
      bit  acc;

      bus.flush_i     = 1'b0;
      bus.in_valid_i  = 1'b0;
      bus.op_i        = OP_SLL;
      bus.a_i         = '0;
      bus.shift_i     = '0;
      bus.tag_i       = '0;
      bus.out_ready_i = 1'b0;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid_o, 1'b0);
      chk("rst_s_o", bus.s_o, 32'h0);
      chk("rst_tag_o", bus.tag_o, 5'd0);
      chk("rst_busy", bus.busy_o, 1'b0);
      chk("rst_in_ready", bus.in_ready_o, 1'b1);

      // Hand-computed values pin the model itself.
      chk("model_sll", ref_shift(OP_SLL, 32'h0000_0001, 31), 32'h8000_0000);
      chk("model_sra", ref_shift(OP_SRA, 32'h8000_0000, 4), 32'hF800_0000);
      chk("model_srl", ref_shift(OP_SRL, 32'h8000_0000, 4), 32'h0800_0000);
      chk("model_rol", ref_shift(OP_ROL, 32'h8000_0001, 1), 32'h0000_0003);
      chk("model_rol0", ref_shift(OP_ROL, 32'h1234_5678, 0), 32'h1234_5678);

      // Back-to-back stream with exact latency
      got.delete();
      exact_lat = 1'b1;
      bus.out_ready_i = 1'b1;
      @(posedge clk); #1;
      issue(OP_SLL, 32'h0000_0001, 31, 5'd3);
      issue(OP_SLL, 32'hDEAD_BEEF, 0, 5'd4);
      issue(OP_SRA, 32'h8000_0000, 4, 5'd5);
      issue(OP_SRL, 32'h8000_0000, 4, 5'd6);
      issue(OP_ROL, 32'h8000_0001, 1, 5'd7);
      wait_drain();
      exact_lat = 1'b0;
      chk("b2b_count", got.size(), 5);
      if (got.size() == 5) begin
         chk("b2b_sll31", got[0].s, 32'h8000_0000);
         chk("b2b_sll31_tag", got[0].tag, 5'd3);
         chk("b2b_sll0", got[1].s, 32'hDEAD_BEEF);
         chk("b2b_sra", got[2].s, 32'hF800_0000);
         chk("b2b_srl", got[3].s, 32'h0800_0000);
         chk("b2b_rol", got[4].s, 32'h0000_0003);
         chk("b2b_rol_tag", got[4].tag, 5'd7);
      end

      // Backpressure
      got.delete();
      bus.out_ready_i = 1'b0;
      issue(OP_SLL, 32'h1, 1, 5'd10);
      issue(OP_SLL, 32'h1, 2, 5'd11);
      bus.in_valid_i = 1'b1;
      bus.op_i       = OP_SLL;
      bus.a_i        = 32'h1;
      bus.shift_i    = SHW'(3);
      bus.tag_i      = 5'd12;
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready", bus.in_ready_o, 1'b0);
         chk("bp_out_valid", bus.out_valid_o, 1'b1);
         chk("bp_hold_s", bus.s_o, 32'h2);
         chk("bp_hold_tag", bus.tag_o, 5'd10);
      end
      @(posedge clk); #1;
      bus.out_ready_i = 1'b1;
      issue(OP_SLL, 32'h1, 3, 5'd12);
      issue(OP_SLL, 32'h1, 4, 5'd13);
      wait_drain();
      chk("bp_count", got.size(), 4);
      if (got.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("bp_order_tag", got[i].tag, 10 + i);
            chk("bp_order_s", got[i].s, 32'h1 << (i + 1));
         end
      end

      // Flush with two in flight, then flush of a same-cycle accept
      got.delete();
      bus.out_ready_i = 1'b0;
      issue(OP_SRL, 32'hF0, 4, 5'd20);
      issue(OP_SRL, 32'hF0, 0, 5'd21);
      bus.in_valid_i = 1'b1;
      bus.tag_i      = 5'd22;
      bus.flush_i    = 1'b1;
      @(posedge clk); #1;
      bus.flush_i    = 1'b0;
      bus.in_valid_i = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", bus.out_valid_o, 1'b0);
      chk("flush_busy", bus.busy_o, 1'b0);
      chk("flush_in_ready", bus.in_ready_o, 1'b1);
      @(posedge clk); #1;
      bus.out_ready_i = 1'b1;
      bus.in_valid_i  = 1'b1;
      bus.tag_i       = 5'd23;
      bus.flush_i     = 1'b1;
      @(posedge clk); #1;
      bus.flush_i    = 1'b0;
      bus.in_valid_i = 1'b0;
      repeat (STAGES + 1) begin
         @(negedge clk);
         chk("flush_drop_valid", bus.out_valid_o, 1'b0);
         chk("flush_drop_busy", bus.busy_o, 1'b0);
      end
      @(posedge clk); #1;
      issue(OP_ROL, 32'h1234_5678, 8, 5'd24);
      wait_drain();
      chk("flush_after_count", got.size(), 1);
      if (got.size() == 1) begin
         chk("flush_after_s", got[0].s, 32'h3456_7812);
         chk("flush_after_tag", got[0].tag, 5'd24);
      end

      // Reset mid-stream with the output stalled
      got.delete();
      bus.out_ready_i = 1'b0;
      issue(OP_SRA, 32'h8000_00F0, 4, 5'd30);
      issue(OP_SLL, 32'h3, 1, 5'd31);
      @(negedge clk);
      chk("rst_pre_valid", bus.out_valid_o, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst2_out_valid", bus.out_valid_o, 1'b0);
      chk("rst2_s_o", bus.s_o, 32'h0);
      chk("rst2_tag_o", bus.tag_o, 5'd0);
      chk("rst2_busy", bus.busy_o, 1'b0);
      chk("rst2_in_ready", bus.in_ready_o, 1'b1);

      // Sweep of every op and shift amount under random valid/ready
      got.delete();
      idx   = 0;
      guard = 0;
      @(posedge clk); #1;
      while (idx < 4 * XLEN && guard < 20000) begin
         bus.out_ready_i = ($urandom_range(0, 3) != 0);
         if (!bus.in_valid_i && $urandom_range(0, 2) != 0) begin
            bus.in_valid_i = 1'b1;
            bus.op_i       = 2'(idx / XLEN);
            bus.shift_i    = SHW'(idx % XLEN);
            bus.a_i        = XLEN'({$urandom, $urandom});
            bus.tag_i      = TAGW'(idx);
         end
         @(negedge clk);
         acc = bus.in_valid_i && bus.in_ready_o;
         @(posedge clk); #1;
         guard++;
         if (acc) begin
            idx++;
            bus.in_valid_i = 1'b0;
         end
      end
      chk("sweep_issued", idx, 4 * XLEN);
      bus.out_ready_i = 1'b1;
      wait_drain();
      chk("sweep_results", got.size(), 4 * XLEN);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/shift_unit_pipe.md
Name: shift_unit_pipe

Overview:
Parametrised, pipelined barrel shifter for the RV32I datapath and its wider/multi-cycle successors. It supports logical left, logical right, arithmetic right and rotate-left on an XLEN-bit operand. The log2(XLEN) shift levels are split across STAGES registered pipeline stages, with a valid/ready handshake on both sides. A sideband tag travels with each operation so the issuing logic can match results to requests (e.g. rd index).

Parameters:
XLEN, 32, operand/result width; power of two, 8..64
SHW, $clog2(XLEN), shift-amount width; derived, not overridden
STAGES, 2, number of pipeline register stages, 1..SHW
TAGW, 5, width of the sideband tag carried with each operation

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous active-high reset
flush_i  in  1  synchronous kill of all in-flight operations
in_valid_i  in  1  request valid
in_ready_o  out  1  unit can accept a request this cycle
op_i  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL
a_i  in  XLEN  operand to shift
shift_i  in  SHW  shift amount, 0..XLEN-1
tag_i  in  TAGW  sideband tag
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
s_o  out  XLEN  shift result
tag_o  out  TAGW  tag of the operation in s_o
busy_o  out  1  at least one stage holds a valid operation

Behaviour:
- Function: SLL = a<<sh with zero fill; SRL = a>>sh with zero fill; SRA = a>>sh with a[XLEN-1] fill; ROL = (a<<sh)|(a>>(XLEN-sh)), with sh=0 giving a. Only shift_i[SHW-1:0] is used; there is no masking beyond SHW bits.
- Level k (shift by 2^k, k=0..SHW-1) is conditioned on shift_i[k].
- Levels are assigned contiguously, ceil(SHW/STAGES) per stage, lowest levels first. Trailing stages with no level assigned are pure registers.
- Each stage registers: valid, data, remaining shift bits, op, tag.
- Latency: a request accepted at edge N gives out_valid_o=1 after edge N+STAGES-1. STAGES=1 gives one-cycle latency: result visible the cycle after the accept.
- Throughput: one operation per cycle when out_ready_i is held high.
- Handshake: a transfer occurs on any edge where valid&&ready.
  - Stage s advances if it is empty, or if its contents move on: s is last and out_ready_i=1, or stage s+1 advances.
  - in_ready_o = stage-0 advance condition. This is a combinational ready chain; no skid buffer.
  - in_valid_i may be asserted while in_ready_o=0; the unit ignores it, and the request must be held.
- Output stability: while out_valid_o=1 and out_ready_i=0, s_o and tag_o hold. Any stage with valid=1 and no space downstream also holds.
- Bubbles: an empty stage is filled from upstream even when downstream is stalled.
- flush_i: on an edge where it is 1, all stage valids clear. This includes an input accepted that same cycle, which is dropped. The next cycle has out_valid_o=0, busy_o=0 and in_ready_o=1. Data registers need not clear.
- Reset: rst_i=1 clears all valids and zeroes all data/tag registers. Outputs after reset: out_valid_o=0, s_o=0, tag_o=0, busy_o=0, in_ready_o=1. Reset takes priority over flush_i and in_valid_i, and aborts any in-flight operation.
- busy_o = OR of all stage valid bits (registered state only).
- No arithmetic overflow exists. All intermediate values are XLEN bits wide.
- The sign bit for SRA is the original a_i[XLEN-1], carried with the operation.

Test Plan:
1. XLEN=32, STAGES=2, out_ready=1: SLL a=0x0000_0001 sh=31 tag=3 → s_o=0x8000_0000, tag_o=3, out_valid 2 edges after accept. SLL a=0xDEAD_BEEF sh=0 → 0xDEAD_BEEF.
2. SRA a=0x8000_0000 sh=4 → 0xF800_0000. SRL same operands → 0x0800_0000. ROL a=0x8000_0001 sh=1 → 0x0000_0003. Results issued back-to-back with one result per cycle and tags in order.
3. Backpressure: issue 4 ops; hold out_ready_i=0 from the first result. in_ready_o drops after STAGES ops are held, and s_o/tag_o are stable. Release out_ready_i and all 4 results drain in issue order with none lost or duplicated.
4. flush_i asserted with 2 ops in flight plus a new accept: no result appears, busy_o=0 and in_ready_o=1 the next cycle. A following op completes normally.
5. rst_i asserted mid-stream with out_valid_o=1 and out_ready_i=0: the next cycle has out_valid_o=0, s_o=0, tag_o=0 and busy_o=0.
6. Exhaustive random sweep, all ops × sh=0..31, for STAGES=1,2,5 and XLEN=64/STAGES=3. Compare against the reference model, check latency = STAGES, and check in-order completion under random in_valid and out_ready.
